// File: rtl/vc_allocator_pkg.sv
// -----------------------------------------------------------------------------
// vc_allocator_pkg
// Router-wide NoC parameters shared by the virtual-channel allocator and its
// arbiter: port count, VCs per port, VC id width and the output-port encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package vc_allocator_pkg;

  localparam int PORT_NUM = 5;
  localparam int VC_NUM   = 2;
  localparam int VC_SIZE  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } port_t;

endpackage

// File: rtl/vc_allocator_arbiter.sv
// -----------------------------------------------------------------------------
// round_robin_arbiter
// N-way arbiter: request vector in, one-hot grant out (combinational).
// Round-robin search starts at an internal pointer; when i_update_en is set
// and a grant is issued, the pointer moves to the slot after the winner.
// Build option: VC_ALLOC_FIXED_PRIO_EN turns the arbiter into a fixed-priority
// (lowest index wins) arbiter with no pointer register.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_req         [N-1:0] request vector
//   i_update_en   allow pointer advance on a grant
//   o_grant       [N-1:0] one-hot grant (zero when no request)
// -----------------------------------------------------------------------------
module round_robin_arbiter #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  input  logic         i_update_en,
  output logic [N-1:0] o_grant
);

`ifdef VC_ALLOC_FIXED_PRIO_EN

  // clk/rst/update are unused without the pointer register
  logic w_unused;
  assign w_unused = &{1'b0, clk, rst, i_update_en};

  // Fixed priority: scan from the top down so the lowest requester is kept last
  always_comb begin
    o_grant = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        o_grant    = '0;
        o_grant[k] = 1'b1;
      end else begin
        o_grant = o_grant;
      end
    end
  end

`else

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic          w_found;
  logic [PW:0]   w_sum;
  logic [PW-1:0] w_idx;

  // Round-robin search beginning at r_ptr, wrapping modulo N
  always_comb begin
    o_grant   = '0;
    w_found   = 1'b0;
    w_ptr_nxt = r_ptr;
    w_sum     = '0;
    w_idx     = '0;
    for (int k = 0; k < N; k++) begin
      // r_ptr < N and k < N, so one subtraction brings the sum back in range
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      w_idx = (w_sum >= (PW+1)'(N)) ? PW'(w_sum - (PW+1)'(N)) : PW'(w_sum);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
        w_ptr_nxt      = (w_idx == PW'(N - 1)) ? '0 : (w_idx + PW'(1));
      end else begin
        w_found = w_found;
      end
    end
  end

  // Pointer register: advances past the winner only when a grant is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_update_en && w_found) begin
      r_ptr <= w_ptr_nxt;
    end else begin
      r_ptr <= r_ptr;
    end
  end

`endif

endmodule

// File: rtl/vc_allocator.sv
// -----------------------------------------------------------------------------
// vc_allocator
// Router-level virtual-channel allocator. Tracks which downstream VCs of every
// output port are free and grants the lowest free VC of a port to one of the
// input VCs requesting that port, chosen by a per-output-port arbiter.
// Grants are combinational (same cycle as the request); availability and the
// arbiter pointers are registered and update on the following edge.
// Build option: VC_ALLOC_FIXED_PRIO_EN selects fixed-priority arbitration
// (lowest requester index wins) instead of round-robin.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   request_i             [PORT_NUM][VC_NUM] input VC wants a downstream VC
//   out_port_i            [PORT_NUM][VC_NUM] routed output port per input VC
//   idle_downstream_vc_i  [PORT_NUM][VC_NUM] pulse: downstream VC released
//   vc_valid_o            [PORT_NUM][VC_NUM] grant pulse per input VC
//   vc_new_o              [PORT_NUM][VC_NUM][VC_SIZE] granted downstream VC id
// -----------------------------------------------------------------------------
module vc_allocator
  import vc_allocator_pkg::*;
#(
  parameter int PORT_NUM = vc_allocator_pkg::PORT_NUM,
  parameter int VC_NUM   = vc_allocator_pkg::VC_NUM,
  parameter int VC_SIZE  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0]          request_i,
  input  port_t [PORT_NUM-1:0][VC_NUM-1:0]          out_port_i,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0]          idle_downstream_vc_i,
  output logic  [PORT_NUM-1:0][VC_NUM-1:0]          vc_valid_o,
  output logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] vc_new_o
);

  localparam int N = PORT_NUM * VC_NUM;

  logic [PORT_NUM-1:0][VC_NUM-1:0]  r_avail;
  logic [PORT_NUM-1:0][VC_NUM-1:0]  w_avail_nxt;
  logic [PORT_NUM-1:0]              w_any_free;
  logic [PORT_NUM-1:0][VC_SIZE-1:0] w_cand_vc;
  logic [PORT_NUM-1:0][N-1:0]       w_elig;
  logic [PORT_NUM-1:0][N-1:0]       w_grant;

  // Stage 1: lowest free downstream VC of each output port
  always_comb begin
    w_any_free = '0;
    w_cand_vc  = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = VC_NUM - 1; v >= 0; v--) begin
        if (r_avail[p][v]) begin
          w_any_free[p] = 1'b1;
          w_cand_vc[p]  = VC_SIZE'(v);
        end else begin
          w_cand_vc[p]  = w_cand_vc[p];
        end
      end
    end
  end

  // Eligibility per output port; rst masks all requests so no grant leaks out
  // during reset. Out-of-range out_port_i values match no port.
  always_comb begin
    w_elig = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int ip = 0; ip < PORT_NUM; ip++) begin
        for (int iv = 0; iv < VC_NUM; iv++) begin
          w_elig[p][ip*VC_NUM + iv] = !rst && w_any_free[p] && request_i[ip][iv]
                                      && (int'(out_port_i[ip][iv]) == p);
        end
      end
    end
  end

  // Stage 2: one arbiter per output port over all PORT_NUM*VC_NUM requesters
  for (genvar gp = 0; gp < PORT_NUM; gp++) begin : g_arb
    round_robin_arbiter #(
      .N (N)
    ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .i_req       (w_elig[gp]),
      .i_update_en (1'b1),
      .o_grant     (w_grant[gp])
    );
  end

  // Fold per-port grants onto the requesters; a requester targets one port,
  // so at most one port can grant it
  always_comb begin
    vc_valid_o = '0;
    vc_new_o   = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int ip = 0; ip < PORT_NUM; ip++) begin
        for (int iv = 0; iv < VC_NUM; iv++) begin
          if (w_grant[p][ip*VC_NUM + iv]) begin
            vc_valid_o[ip][iv] = 1'b1;
            vc_new_o[ip][iv]   = w_cand_vc[p];
          end else begin
            vc_new_o[ip][iv]   = vc_new_o[ip][iv];
          end
        end
      end
    end
  end

  // Next availability: clear the granted VC, then apply releases. A release
  // can never hit the granted VC because grants only pick available VCs.
  always_comb begin
    w_avail_nxt = r_avail;
    for (int p = 0; p < PORT_NUM; p++) begin
      if (|w_grant[p]) begin
        w_avail_nxt[p][w_cand_vc[p]] = 1'b0;
      end else begin
        w_avail_nxt[p] = w_avail_nxt[p];
      end
    end
    w_avail_nxt = w_avail_nxt | idle_downstream_vc_i;
  end

  // Availability register: every downstream VC is free after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_avail <= '1;
    end else begin
      r_avail <= w_avail_nxt;
    end
  end

endmodule

// File: tb/tb_vc_allocator.sv
module tb_vc_allocator
  import vc_allocator_pkg::*;
;

  localparam int P  = 5;
  localparam int V  = 2;
  localparam int N  = P * V;
  localparam int VS = 1;

  logic clk = 1'b0;
  logic rst;
  logic  [P-1:0][V-1:0]         req;
  port_t [P-1:0][V-1:0]         op;
  logic  [P-1:0][V-1:0]         idle;
  logic  [P-1:0][V-1:0]         vld;
  logic  [P-1:0][V-1:0][VS-1:0] vnew;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit m_avail [P][V];
  int m_rr    [P];

  always #5 clk = ~clk;

  vc_allocator #(.PORT_NUM(P), .VC_NUM(V), .VC_SIZE(VS)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .request_i            (req),
    .out_port_i           (op),
    .idle_downstream_vc_i (idle),
    .vc_valid_o           (vld),
    .vc_new_o             (vnew)
  );

  task automatic model_reset();
    for (int p = 0; p < P; p++) begin
      m_rr[p] = 0;
      for (int v = 0; v < V; v++) m_avail[p][v] = 1'b1;
    end
  endtask

  task automatic clear_inputs();
    req  = '0;
    idle = '0;
    for (int p = 0; p < P; p++)
      for (int v = 0; v < V; v++) op[p][v] = LOCAL;
  endtask

  task automatic set_req(input int r, input port_t dst);
    req[r / V][r % V] = 1'b1;
    op[r / V][r % V]  = dst;
  endtask

  // Compare every requester against the model, then take the edge and
  // update the model: grant consumes lowest free VC, pointer goes past winner.
  task automatic model_check_tick(input string tag);
    bit ev [N];
    int en [N];
    int win [P];
    int fvc [P];
    int idx;
    #1;
    for (int r = 0; r < N; r++) begin ev[r] = 1'b0; en[r] = 0; end
    for (int p = 0; p < P; p++) begin
      win[p] = -1;
      fvc[p] = -1;
      for (int v = V - 1; v >= 0; v--) if (m_avail[p][v]) fvc[p] = v;
      if (fvc[p] >= 0) begin
        for (int k = 0; k < N; k++) begin
`ifdef VC_ALLOC_FIXED_PRIO_EN
          idx = k;
`else
          idx = (m_rr[p] + k) % N;
`endif
          if (win[p] < 0 && req[idx / V][idx % V] && int'(op[idx / V][idx % V]) == p)
            win[p] = idx;
        end
      end
      if (win[p] >= 0) begin ev[win[p]] = 1'b1; en[win[p]] = fvc[p]; end
    end
    for (int r = 0; r < N; r++) begin
      n_tests++;
      if (vld[r / V][r % V] !== ev[r]) begin
        n_fail++;
        $display("FAIL %s valid r=%0d got %0b want %0b", tag, r, vld[r / V][r % V], ev[r]);
      end
      if (ev[r]) begin
        n_tests++;
        if (vnew[r / V][r % V] !== VS'(en[r])) begin
          n_fail++;
          $display("FAIL %s vc_new r=%0d got %0d want %0d", tag, r, vnew[r / V][r % V], en[r]);
        end
      end
    end
    @(posedge clk);
    for (int p = 0; p < P; p++) begin
      if (win[p] >= 0) begin
        m_avail[p][fvc[p]] = 1'b0;
        m_rr[p] = (win[p] + 1) % N;
      end
    end
    for (int p = 0; p < P; p++)
      for (int v = 0; v < V; v++) if (idle[p][v]) m_avail[p][v] = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    set_req(0, NORTH);
    #1;
    n_tests++;
    if (vld !== '0 || vnew !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got valid=%b new=%b want 0", vld, vnew);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    model_check_tick("reset_first_req");
  endtask

  task automatic test_single();
    do_reset();
    set_req(1, EAST);
    #1;
    n_tests++;
    if (vld[0][1] !== 1'b1 || vnew[0][1] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_first got valid=%0b new=%0d want valid=1 new=0", vld[0][1], vnew[0][1]);
    end
    model_check_tick("single_first");
    #1;
    n_tests++;
    if (vld[0][1] !== 1'b1 || vnew[0][1] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_repeat got valid=%0b new=%0d want valid=1 new=1", vld[0][1], vnew[0][1]);
    end
    model_check_tick("single_repeat");
  endtask

  task automatic test_exhaustion();
    do_reset();
    set_req(2, EAST);
    model_check_tick("exh_a");
    clear_inputs();
    set_req(5, EAST);
    model_check_tick("exh_b");
    clear_inputs();
    set_req(7, EAST);
    idle[EAST][0] = 1'b1;
    #1;
    n_tests++;
    if (vld !== '0) begin
      n_fail++;
      $display("FAIL exh_none got valid=%b want 0", vld);
    end
    model_check_tick("exh_c");
    idle = '0;
    #1;
    n_tests++;
    if (vld[3][1] !== 1'b1 || vnew[3][1] !== 1'b0) begin
      n_fail++;
      $display("FAIL exh_after_release got valid=%0b new=%0d want valid=1 new=0", vld[3][1], vnew[3][1]);
    end
    model_check_tick("exh_d");
  endtask

  task automatic test_round_robin();
    int want;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      set_req(1, NORTH);
      set_req(4, NORTH);
      if (i > 0) idle[NORTH][(i - 1) % 2] = 1'b1;
`ifdef VC_ALLOC_FIXED_PRIO_EN
      want = 1;
`else
      want = (i % 2 == 0) ? 1 : 4;
`endif
      #1;
      n_tests++;
      if (vld[want / V][want % V] !== 1'b1 || vnew[want / V][want % V] !== VS'(i % 2)) begin
        n_fail++;
        $display("FAIL rr_winner cycle=%0d got valid=%b want r=%0d new=%0d", i, vld, want, i % 2);
      end
      model_check_tick("rr");
    end
  endtask

  task automatic test_parallel();
    do_reset();
    set_req(0, EAST);
    set_req(2, WEST);
    #1;
    n_tests++;
    if (vld[0][0] !== 1'b1 || vld[1][0] !== 1'b1 || vnew[0][0] !== 1'b0 || vnew[1][0] !== 1'b0) begin
      n_fail++;
      $display("FAIL parallel got valid=%b new=%b want r0,r2 granted vc0", vld, vnew);
    end
    model_check_tick("parallel");
  endtask

  task automatic test_release_and_grant();
    do_reset();
    set_req(0, EAST);
    model_check_tick("rg_fill0");
    clear_inputs();
    set_req(1, EAST);
    model_check_tick("rg_fill1");
    clear_inputs();
    idle[EAST][0] = 1'b1;
    model_check_tick("rg_free0");
    clear_inputs();
    set_req(3, EAST);
    idle[EAST][1] = 1'b1;
    #1;
    n_tests++;
    if (vld[1][1] !== 1'b1 || vnew[1][1] !== 1'b0) begin
      n_fail++;
      $display("FAIL rg_grant got valid=%0b new=%0d want valid=1 new=0", vld[1][1], vnew[1][1]);
    end
    model_check_tick("rg_grant");
    clear_inputs();
    set_req(5, EAST);
    #1;
    n_tests++;
    if (vld[2][1] !== 1'b1 || vnew[2][1] !== 1'b1) begin
      n_fail++;
      $display("FAIL rg_vc1_free got valid=%0b new=%0d want valid=1 new=1", vld[2][1], vnew[2][1]);
    end
    model_check_tick("rg_next");
    clear_inputs();
    set_req(6, EAST);
    model_check_tick("rg_full");
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, EAST);
    model_check_tick("rm_fill0");
    clear_inputs();
    set_req(1, EAST);
    model_check_tick("rm_fill1");
    clear_inputs();
    set_req(4, NORTH);
    set_req(2, EAST);
    #1;
    n_tests++;
    if (vld[2][0] !== 1'b1 || vld[1][0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_before got valid=%b want only r4", vld);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (vld !== '0 || vnew !== '0) begin
      n_fail++;
      $display("FAIL rm_async got valid=%b new=%b want 0", vld, vnew);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    clear_inputs();
    set_req(9, EAST);
    #1;
    n_tests++;
    if (vld[4][1] !== 1'b1 || vnew[4][1] !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_after got valid=%0b new=%0d want valid=1 new=0", vld[4][1], vnew[4][1]);
    end
    model_check_tick("rm_after");
  endtask

  task automatic test_out_of_range();
    do_reset();
    set_req(3, port_t'(3'd6));
    set_req(8, port_t'(3'd5));
    #1;
    n_tests++;
    if (vld !== '0) begin
      n_fail++;
      $display("FAIL oor got valid=%b want 0", vld);
    end
    model_check_tick("oor");
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      clear_inputs();
      for (int r = 0; r < N; r++) begin
        if ($urandom % 3 == 0) begin
          if ($urandom % 8 == 0) set_req(r, port_t'(3'(5 + $urandom % 3)));
          else                   set_req(r, port_t'(3'($urandom % 5)));
        end
      end
      // only release VCs the model holds as allocated
      for (int p = 0; p < P; p++)
        for (int v = 0; v < V; v++)
          if (!m_avail[p][v] && ($urandom % 4 == 0)) idle[p][v] = 1'b1;
      model_check_tick("random");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_exhaustion();
    test_round_robin();
    test_parallel();
    test_release_and_grant();
    test_reset_mid();
    test_out_of_range();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
